alu_seq_controller: RTL and testbench

Parametrised one-hot sequencer for the multi-cycle ALU. It drives a WIDTH-bit Booth multiplier datapath, a non-restoring divider datapath and a single-cycle add/sub path. It owns its own iteration counter, so the datapaths no longer supply done flags. It adds divide-by-zero trapping, a busy/done handshake and illegal-state recovery, and sits between the ALU top-level command interface and the datapath register enables.

---
 rtl/alu_seq_controller.sv | 145 ++++++++++++++
 tb/tb_alu_seq_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_controller.sv
// One-hot sequencer for the multi-cycle ALU: add/sub, Booth multiply and
// non-restoring divide, with its own iteration counter and divide-by-zero trap.
module alu_seq_controller #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             begin_op,
    input  logic [1:0]       opcode,
    input  logic             divisor_zero,
    input  logic             booth_Q0,
    input  logic             booth_Qm1,
    input  logic             div_R_sign,
    output logic             busy,
    output logic             addsub_en,
    output logic             addsub_sub,
    output logic             booth_load,
    output logic             booth_add_en,
    output logic             booth_sub_en,
    output logic             booth_shift_en,
    output logic             div_load,
    output logic             div_shift_en,
    output logic             div_add_en,
    output logic             div_sub_en,
    output logic             div_final_add,
    output logic [CNT_W-1:0] iter_count,
    output logic             div_by_zero,
    output logic             alu_done
);

    typedef enum logic [9:0] {
        S_IDLE      = 10'b00_0000_0001,
        S_AS_EXEC   = 10'b00_0000_0010,
        S_MUL_LOAD  = 10'b00_0000_0100,
        S_MUL_OP    = 10'b00_0000_1000,
        S_MUL_SHIFT = 10'b00_0001_0000,
        S_DIV_LOAD  = 10'b00_0010_0000,
        S_DIV_SHIFT = 10'b00_0100_0000,
        S_DIV_OP    = 10'b00_1000_0000,
        S_DIV_FINAL = 10'b01_0000_0000,
        S_DONE      = 10'b10_0000_0000
    } state_t;

    localparam logic [CNT_W-1:0] ITER_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ITER_ONE  = CNT_W'(1);

    state_t state;
    state_t state_next;
    logic   op_sub;

    // Any encoding outside the ten legal one-hot values falls to default -> IDLE.
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE: begin
                if (begin_op) begin
                    case (opcode)
                        2'b00, 2'b01: state_next = S_AS_EXEC;
                        2'b10:        state_next = S_MUL_LOAD;
                        default:      state_next = divisor_zero ? S_DONE : S_DIV_LOAD;
                    endcase
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_AS_EXEC:   state_next = S_DONE;
            S_MUL_LOAD:  state_next = S_MUL_OP;
            S_MUL_OP:    state_next = S_MUL_SHIFT;
            S_MUL_SHIFT: state_next = (iter_count == ITER_ONE) ? S_DONE : S_MUL_OP;
            S_DIV_LOAD:  state_next = S_DIV_SHIFT;
            S_DIV_SHIFT: state_next = S_DIV_OP;
            S_DIV_OP:    state_next = (iter_count == '0) ? S_DIV_FINAL : S_DIV_SHIFT;
            S_DIV_FINAL: state_next = S_DONE;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            iter_count  <= '0;
            div_by_zero <= 1'b0;
            op_sub      <= 1'b0;
            busy        <= 1'b0;
            alu_done    <= 1'b0;
        end else begin
            state    <= state_next;
            busy     <= (state_next != S_IDLE);
            alu_done <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (begin_op) begin
                        div_by_zero <= (opcode == 2'b11) && divisor_zero;
                        op_sub      <= opcode[0];
                    end
                end
                S_MUL_LOAD, S_DIV_LOAD: iter_count <= ITER_LOAD;
                S_MUL_SHIFT, S_DIV_SHIFT: begin
                    if (iter_count != '0) begin
                        iter_count <= iter_count - ITER_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are a pure decode of the state plus the datapath sense bits.
    always_comb begin
        addsub_en      = 1'b0;
        addsub_sub     = 1'b0;
        booth_load     = 1'b0;
        booth_add_en   = 1'b0;
        booth_sub_en   = 1'b0;
        booth_shift_en = 1'b0;
        div_load       = 1'b0;
        div_shift_en   = 1'b0;
        div_add_en     = 1'b0;
        div_sub_en     = 1'b0;
        div_final_add  = 1'b0;
        case (state)
            S_AS_EXEC: begin
                addsub_en  = 1'b1;
                addsub_sub = op_sub;
            end
            S_MUL_LOAD:  booth_load = 1'b1;
            S_MUL_OP: begin
                booth_add_en = ~booth_Q0 & booth_Qm1;
                booth_sub_en = booth_Q0 & ~booth_Qm1;
            end
            S_MUL_SHIFT: booth_shift_en = 1'b1;
            S_DIV_LOAD:  div_load = 1'b1;
            S_DIV_SHIFT: div_shift_en = 1'b1;
            S_DIV_OP: begin
                div_add_en = div_R_sign;
                div_sub_en = ~div_R_sign;
            end
            S_DIV_FINAL: div_final_add = div_R_sign;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_controller.sv
// Bench for alu_seq_controller: directed and randomized operations on WIDTH=8
// and WIDTH=16 instances, checked every cycle against a cycle-index trace model.
module tb_alu_seq_controller;

    localparam int B_BUSY   = 13;
    localparam int B_ASEN   = 12;
    localparam int B_ASSUB  = 11;
    localparam int B_BLOAD  = 10;
    localparam int B_BADD   = 9;
    localparam int B_BSUB   = 8;
    localparam int B_BSHIFT = 7;
    localparam int B_DLOAD  = 6;
    localparam int B_DSHIFT = 5;
    localparam int B_DADD   = 4;
    localparam int B_DSUB   = 3;
    localparam int B_DFIN   = 2;
    localparam int B_DBZ    = 1;
    localparam int B_DONE   = 0;

    logic       clk = 1'b0;
    logic       reset_w8, reset_w16, begin_w8, begin_w16;
    logic [1:0] opcode;
    logic       divisor_zero, booth_Q0, booth_Qm1, div_R_sign;

    logic       busy_w8, addsub_en_w8, addsub_sub_w8, booth_load_w8, booth_add_en_w8;
    logic       booth_sub_en_w8, booth_shift_en_w8, div_load_w8, div_shift_en_w8;
    logic       div_add_en_w8, div_sub_en_w8, div_final_add_w8, div_by_zero_w8, alu_done_w8;
    logic [3:0] iter_count_w8;

    logic       busy_w16, addsub_en_w16, addsub_sub_w16, booth_load_w16, booth_add_en_w16;
    logic       booth_sub_en_w16, booth_shift_en_w16, div_load_w16, div_shift_en_w16;
    logic       div_add_en_w16, div_sub_en_w16, div_final_add_w16, div_by_zero_w16, alu_done_w16;
    logic [4:0] iter_count_w16;

    int   checks = 0;
    int   errors = 0;
    logic exp_dbz_w8 = 1'b0;
    logic exp_dbz_w16 = 1'b0;

    always #5 clk = ~clk;

    alu_seq_controller #(.WIDTH(8), .CNT_W(4)) dut_w8 (
        .clk(clk), .reset(reset_w8), .begin_op(begin_w8), .opcode(opcode),
        .divisor_zero(divisor_zero), .booth_Q0(booth_Q0), .booth_Qm1(booth_Qm1),
        .div_R_sign(div_R_sign), .busy(busy_w8), .addsub_en(addsub_en_w8),
        .addsub_sub(addsub_sub_w8), .booth_load(booth_load_w8),
        .booth_add_en(booth_add_en_w8), .booth_sub_en(booth_sub_en_w8),
        .booth_shift_en(booth_shift_en_w8), .div_load(div_load_w8),
        .div_shift_en(div_shift_en_w8), .div_add_en(div_add_en_w8),
        .div_sub_en(div_sub_en_w8), .div_final_add(div_final_add_w8),
        .iter_count(iter_count_w8), .div_by_zero(div_by_zero_w8), .alu_done(alu_done_w8)
    );

    alu_seq_controller #(.WIDTH(16), .CNT_W(5)) dut_w16 (
        .clk(clk), .reset(reset_w16), .begin_op(begin_w16), .opcode(opcode),
        .divisor_zero(divisor_zero), .booth_Q0(booth_Q0), .booth_Qm1(booth_Qm1),
        .div_R_sign(div_R_sign), .busy(busy_w16), .addsub_en(addsub_en_w16),
        .addsub_sub(addsub_sub_w16), .booth_load(booth_load_w16),
        .booth_add_en(booth_add_en_w16), .booth_sub_en(booth_sub_en_w16),
        .booth_shift_en(booth_shift_en_w16), .div_load(div_load_w16),
        .div_shift_en(div_shift_en_w16), .div_add_en(div_add_en_w16),
        .div_sub_en(div_sub_en_w16), .div_final_add(div_final_add_w16),
        .iter_count(iter_count_w16), .div_by_zero(div_by_zero_w16), .alu_done(alu_done_w16)
    );

    function automatic logic [13:0] obs(input bit sel16);
        if (sel16)
            return {busy_w16, addsub_en_w16, addsub_sub_w16, booth_load_w16, booth_add_en_w16,
                    booth_sub_en_w16, booth_shift_en_w16, div_load_w16, div_shift_en_w16,
                    div_add_en_w16, div_sub_en_w16, div_final_add_w16, div_by_zero_w16,
                    alu_done_w16};
        return {busy_w8, addsub_en_w8, addsub_sub_w8, booth_load_w8, booth_add_en_w8,
                booth_sub_en_w8, booth_shift_en_w8, div_load_w8, div_shift_en_w8,
                div_add_en_w8, div_sub_en_w8, div_final_add_w8, div_by_zero_w8, alu_done_w8};
    endfunction

    function automatic int cnt_obs(input bit sel16);
        return sel16 ? int'(iter_count_w16) : int'(iter_count_w8);
    endfunction

    task automatic check(input string tag, input int k, input bit sel16,
                         input logic [13:0] exp_v, input int exp_c);
        logic [13:0] got_v;
        int          got_c;
        got_v = obs(sel16);
        got_c = cnt_obs(sel16);
        checks++;
        assert (got_v === exp_v) else begin
            errors++;
            $error("FAIL %s k=%0d outputs got %b expected %b", tag, k, got_v, exp_v);
        end
        checks++;
        assert (got_c === exp_c) else begin
            errors++;
            $error("FAIL %s k=%0d iter_count got %0d expected %0d", tag, k, got_c, exp_c);
        end
    endtask

    task automatic set_begin(input bit sel16, input logic v);
        if (sel16) begin_w16 = v; else begin_w8 = v;
    endtask

    task automatic set_reset(input bit sel16, input logic v);
        if (sel16) reset_w16 = v; else reset_w8 = v;
    endtask

    task automatic drive_dp(input bit rnd, input logic q0, input logic qm1, input logic rs);
        if (rnd) begin
            booth_Q0   = 1'($urandom_range(0, 1));
            booth_Qm1  = 1'($urandom_range(0, 1));
            div_R_sign = 1'($urandom_range(0, 1));
        end else begin
            booth_Q0   = q0;
            booth_Qm1  = qm1;
            div_R_sign = rs;
        end
    endtask

    task automatic idle_check(input string tag, input bit sel16, input int n);
        logic [13:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_begin(sel16, 1'b0);
            opcode       = 2'($urandom);
            divisor_zero = 1'($urandom_range(0, 1));
            drive_dp(1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            e = '0;
            e[B_DBZ] = sel16 ? exp_dbz_w16 : exp_dbz_w8;
            check(tag, i, sel16, e, 0);
        end
    endtask

    // Expected trace is indexed by cycles since acceptance (k=1 is the first busy cycle).
    task automatic run_op(input string tag, input bit sel16, input logic [1:0] op,
                          input logic dz, input bit rnd, input logic q0, input logic qm1,
                          input logic rs, input int abort_k);
        int          w, lat, c;
        logic [13:0] e;
        logic        dbz;
        w = sel16 ? 16 : 8;
        if (op[1] == 1'b0)  lat = 2;
        else if (op == 2'b10) lat = 2 * w + 2;
        else if (dz)        lat = 1;
        else                lat = 2 * w + 3;

        @(negedge clk);
        set_begin(sel16, 1'b1);
        opcode       = op;
        divisor_zero = dz;
        drive_dp(rnd, q0, qm1, rs);
        #1;
        e = '0;
        e[B_DBZ] = sel16 ? exp_dbz_w16 : exp_dbz_w8;
        check({tag, "_idle"}, 0, sel16, e, 0);
        dbz = (op == 2'b11) && dz;
        if (sel16) exp_dbz_w16 = dbz; else exp_dbz_w8 = dbz;

        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            set_begin(sel16, 1'($urandom_range(0, 1)));
            opcode       = 2'($urandom);
            divisor_zero = 1'($urandom_range(0, 1));
            drive_dp(rnd, q0, qm1, rs);
            #1;
            e = '0;
            e[B_BUSY] = 1'b1;
            e[B_DBZ]  = dbz;
            c = 0;
            if (op[1] == 1'b0) begin
                if (k == 1) begin
                    e[B_ASEN]  = 1'b1;
                    e[B_ASSUB] = op[0];
                end else e[B_DONE] = 1'b1;
            end else if (op == 2'b10) begin
                if (k == 1) e[B_BLOAD] = 1'b1;
                else if (k <= 2 * w + 1) begin
                    c = w - (k - 2) / 2;
                    if (k % 2 == 0) begin
                        e[B_BADD] = ~booth_Q0 & booth_Qm1;
                        e[B_BSUB] = booth_Q0 & ~booth_Qm1;
                    end else e[B_BSHIFT] = 1'b1;
                end else e[B_DONE] = 1'b1;
            end else if (dz) begin
                e[B_DONE] = 1'b1;
            end else begin
                if (k == 1) e[B_DLOAD] = 1'b1;
                else if (k <= 2 * w + 1) begin
                    c = w - (k - 1) / 2;
                    if (k % 2 == 0) e[B_DSHIFT] = 1'b1;
                    else begin
                        e[B_DADD] = div_R_sign;
                        e[B_DSUB] = ~div_R_sign;
                    end
                end else if (k == 2 * w + 2) e[B_DFIN] = div_R_sign;
                else e[B_DONE] = 1'b1;
            end
            check(tag, k, sel16, e, c);

            if (k == abort_k) begin
                set_reset(sel16, 1'b1);
                @(negedge clk);
                #1;
                if (sel16) exp_dbz_w16 = 1'b0; else exp_dbz_w8 = 1'b0;
                check({tag, "_reset"}, k + 1, sel16, '0, 0);
                set_reset(sel16, 1'b0);
                set_begin(sel16, 1'b0);
                return;
            end
        end
    endtask

    initial begin
        reset_w8 = 1'b1;  reset_w16 = 1'b1;
        begin_w8 = 1'b1;  begin_w16 = 1'b1;
        opcode = 2'b10;   divisor_zero = 1'b0;
        drive_dp(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("reset_w8", i, 1'b0, '0, 0);
            check("reset_w16", i, 1'b1, '0, 0);
        end
        reset_w8 = 1'b0;  reset_w16 = 1'b0;
        begin_w8 = 1'b0;  begin_w16 = 1'b0;
        idle_check("idle_w8", 1'b0, 5);

        run_op("mul_sub", 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run_op("div_neg", 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_op("div_pos", 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op("div_zero", 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_check("dbz_hold", 1'b0, 3);
        run_op("add_clr", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_op("sub", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            logic [1:0] rop;
            logic       rdz;
            rop = 2'($urandom);
            rdz = 1'($urandom_range(0, 1));
            run_op("rand_w8", 1'b0, rop, rdz, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        end

        run_op("mul_abort", 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        run_op("div_after", 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_check("end_w8", 1'b0, 2);

        idle_check("idle_w16", 1'b1, 2);
        run_op("mul_abort16", 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        run_op("div_w16", 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_op("mul_w16", 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_op("dz_w16", 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_check("end_w16", 1'b1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
